// File: rtl/clkgen_cfg_seq.sv
// clkgen_cfg_seq: table-driven I2C configuration sequencer for clock generators.
// It walks a 256-entry ROM of WRITE / POLL / DELAY / END entries and drives a
// simple I2C master through a valid/ready request and a response strobe.
// Optional feature: define CFG_SEQ_READBACK_EN so that every acked WRITE is
// verified by a read of the same register before the entry counts as done.
module clkgen_cfg_seq #(
    parameter int unsigned POR_CYCLES = 32'd10_000_000,
    parameter int unsigned RETRY_MAX  = 32'd3,
    parameter int unsigned POLL_LIMIT = 32'd255,
    parameter int unsigned POLL_GAP   = 32'd1024
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    output logic [7:0]  tbl_addr,
    input  logic [31:0] tbl_data,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [6:0]  req_dev,
    output logic        req_rw,
    output logic [7:0]  req_reg,
    output logic [7:0]  req_wdata,
    input  logic        rsp_valid,
    input  logic        rsp_nack,
    input  logic [7:0]  rsp_rdata,
    output logic        busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [7:0]  err_index
);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_POR_WAIT = 4'd1,
        ST_FETCH    = 4'd2,
        ST_DECODE   = 4'd3,
        ST_ISSUE    = 4'd4,
        ST_WAIT_RSP = 4'd5,
        ST_GAP      = 4'd6,
        ST_DELAY    = 4'd7,
        ST_DONE     = 4'd8,
        ST_ERROR    = 4'd9
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_POLL  = 2'b01;
    localparam logic [1:0] OP_DELAY = 2'b10;

    // dev_sel bit picks one of the two clock generator parts on the bus
    function automatic logic [6:0] dev_addr(input logic sel);
        return sel ? 7'h70 : 7'h60;
    endfunction

    // a POLL read matches when the masked bits equal the masked expectation
    function automatic logic poll_match(input logic [7:0] rdata,
                                        input logic [7:0] data,
                                        input logic [7:0] mask);
        return (rdata & mask) == (data & mask);
    endfunction

    state_t      state_r;
    logic [31:0] cnt_r;
    logic [31:0] retry_cnt_r;
    logic [31:0] poll_cnt_r;
    logic [1:0]  ent_op_r;
    logic [7:0]  ent_data_r;
    logic [7:0]  ent_mask_r;
    logic [25:0] delay_len_r;
`ifdef CFG_SEQ_READBACK_EN
    logic        rb_phase_r;
`endif

    logic rsp_ok_s;
    logic rsp_fail_s;
    logic poll_miss_s;
    logic wr_ack_s;
    logic por_last_s;
    logic gap_last_s;
    logic delay_last_s;
    logic last_entry_s;
    logic retry_exhausted_s;
    logic poll_exhausted_s;
    logic rsvd_unused_s;

    // reserved entry bits carry no meaning
    assign rsvd_unused_s = ^tbl_data[28:24];

    assign por_last_s        = (cnt_r + 32'd1) >= POR_CYCLES;
    assign gap_last_s        = (cnt_r + 32'd1) >= POLL_GAP;
    assign delay_last_s      = (cnt_r + 32'd1) >= {6'd0, delay_len_r};
    assign last_entry_s      = (tbl_addr == 8'hFF);
    assign retry_exhausted_s = (retry_cnt_r >= RETRY_MAX);
    assign poll_exhausted_s  = (poll_cnt_r >= POLL_LIMIT);

    // classify a completed I2C transaction; responses outside WAIT_RSP are dropped
    always_comb begin
        rsp_ok_s    = 1'b0;
        rsp_fail_s  = 1'b0;
        poll_miss_s = 1'b0;
        wr_ack_s    = 1'b0;
        if ((state_r == ST_WAIT_RSP) && rsp_valid) begin
            if (rsp_nack) begin
                rsp_fail_s = 1'b1;
            end else if (ent_op_r == OP_POLL) begin
                if (poll_match(rsp_rdata, ent_data_r, ent_mask_r)) begin
                    rsp_ok_s = 1'b1;
                end else begin
                    poll_miss_s = 1'b1;
                end
            end else begin
`ifdef CFG_SEQ_READBACK_EN
                if (!rb_phase_r) begin
                    wr_ack_s = 1'b1;
                end else if (rsp_rdata == ent_data_r) begin
                    rsp_ok_s = 1'b1;
                end else begin
                    rsp_fail_s = 1'b1;
                end
`else
                rsp_ok_s = 1'b1;
`endif
            end
        end else begin
            rsp_ok_s = 1'b0;
        end
    end

    // sequencer FSM with all outputs registered
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r     <= ST_POR_WAIT;
            tbl_addr    <= 8'd0;
            req_valid   <= 1'b0;
            req_dev     <= 7'd0;
            req_rw      <= 1'b0;
            req_reg     <= 8'd0;
            req_wdata   <= 8'd0;
            busy        <= 1'b0;
            cfg_done    <= 1'b0;
            cfg_err     <= 1'b0;
            err_index   <= 8'd0;
            cnt_r       <= 32'd0;
            retry_cnt_r <= 32'd0;
            poll_cnt_r  <= 32'd0;
            ent_op_r    <= 2'b00;
            ent_data_r  <= 8'd0;
            ent_mask_r  <= 8'd0;
            delay_len_r <= 26'd0;
`ifdef CFG_SEQ_READBACK_EN
            rb_phase_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // not entered in normal operation; fall back to a fresh power-on wait
                    busy    <= 1'b1;
                    cnt_r   <= 32'd0;
                    state_r <= ST_POR_WAIT;
                end

                ST_POR_WAIT: begin
                    busy <= 1'b1;
                    if (por_last_s) begin
                        cnt_r    <= 32'd0;
                        tbl_addr <= 8'd0;
                        state_r  <= ST_FETCH;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end

                ST_FETCH: begin
                    // tbl_addr is already on the ROM; its data is ready next cycle
                    state_r <= ST_DECODE;
                end

                ST_DECODE: begin
                    ent_op_r    <= tbl_data[31:30];
                    ent_data_r  <= tbl_data[15:8];
                    ent_mask_r  <= tbl_data[7:0];
                    delay_len_r <= {tbl_data[15:0], 10'd0};
                    req_dev     <= dev_addr(tbl_data[29]);
                    req_reg     <= tbl_data[23:16];
                    req_wdata   <= tbl_data[15:8];
                    case (tbl_data[31:30])
                        OP_WRITE: begin
                            req_rw    <= 1'b0;
                            req_valid <= 1'b1;
                            state_r   <= ST_ISSUE;
                        end
                        OP_POLL: begin
                            req_rw    <= 1'b1;
                            req_valid <= 1'b1;
                            state_r   <= ST_ISSUE;
                        end
                        OP_DELAY: begin
                            if (tbl_data[15:0] == 16'd0) begin
                                retry_cnt_r <= 32'd0;
                                poll_cnt_r  <= 32'd0;
                                if (last_entry_s) begin
                                    busy     <= 1'b0;
                                    cfg_done <= 1'b1;
                                    state_r  <= ST_DONE;
                                end else begin
                                    tbl_addr <= tbl_addr + 8'd1;
                                    state_r  <= ST_FETCH;
                                end
                            end else begin
                                cnt_r   <= 32'd0;
                                state_r <= ST_DELAY;
                            end
                        end
                        default: begin
                            busy     <= 1'b0;
                            cfg_done <= 1'b1;
                            state_r  <= ST_DONE;
                        end
                    endcase
                end

                ST_ISSUE: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        state_r   <= ST_WAIT_RSP;
                    end else begin
                        req_valid <= 1'b1;
                    end
                end

                ST_WAIT_RSP: begin
                    if (rsp_fail_s) begin
                        if (retry_exhausted_s) begin
                            busy      <= 1'b0;
                            cfg_err   <= 1'b1;
                            err_index <= tbl_addr;
                            state_r   <= ST_ERROR;
                        end else begin
                            // a retry always restarts the entry from its first transfer
                            retry_cnt_r <= retry_cnt_r + 32'd1;
                            req_rw      <= (ent_op_r == OP_POLL);
                            req_valid   <= 1'b1;
                            state_r     <= ST_ISSUE;
                        end
`ifdef CFG_SEQ_READBACK_EN
                        rb_phase_r <= 1'b0;
`endif
                    end else if (rsp_ok_s) begin
                        retry_cnt_r <= 32'd0;
                        poll_cnt_r  <= 32'd0;
`ifdef CFG_SEQ_READBACK_EN
                        rb_phase_r  <= 1'b0;
`endif
                        if (last_entry_s) begin
                            busy     <= 1'b0;
                            cfg_done <= 1'b1;
                            state_r  <= ST_DONE;
                        end else begin
                            tbl_addr <= tbl_addr + 8'd1;
                            state_r  <= ST_FETCH;
                        end
                    end else if (poll_miss_s) begin
                        if (poll_exhausted_s) begin
                            busy      <= 1'b0;
                            cfg_err   <= 1'b1;
                            err_index <= tbl_addr;
                            state_r   <= ST_ERROR;
                        end else begin
                            poll_cnt_r <= poll_cnt_r + 32'd1;
                            cnt_r      <= 32'd0;
                            state_r    <= ST_GAP;
                        end
                    end else if (wr_ack_s) begin
`ifdef CFG_SEQ_READBACK_EN
                        rb_phase_r <= 1'b1;
`endif
                        req_rw    <= 1'b1;
                        req_valid <= 1'b1;
                        state_r   <= ST_ISSUE;
                    end else begin
                        req_valid <= 1'b0;
                    end
                end

                ST_GAP: begin
                    if (gap_last_s) begin
                        cnt_r     <= 32'd0;
                        req_valid <= 1'b1;
                        state_r   <= ST_ISSUE;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end

                ST_DELAY: begin
                    if (delay_last_s) begin
                        cnt_r       <= 32'd0;
                        retry_cnt_r <= 32'd0;
                        poll_cnt_r  <= 32'd0;
                        if (last_entry_s) begin
                            busy     <= 1'b0;
                            cfg_done <= 1'b1;
                            state_r  <= ST_DONE;
                        end else begin
                            tbl_addr <= tbl_addr + 8'd1;
                            state_r  <= ST_FETCH;
                        end
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end

                ST_DONE, ST_ERROR: begin
                    // restart without a power-on wait; statuses stay held until then
                    if (start) begin
                        cfg_done    <= 1'b0;
                        cfg_err     <= 1'b0;
                        err_index   <= 8'd0;
                        tbl_addr    <= 8'd0;
                        retry_cnt_r <= 32'd0;
                        poll_cnt_r  <= 32'd0;
                        cnt_r       <= 32'd0;
                        busy        <= 1'b1;
                        state_r     <= ST_FETCH;
                    end else begin
                        busy <= 1'b0;
                    end
                end

                default: begin
                    req_valid <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clkgen_cfg_seq.sv
// Testbench for clkgen_cfg_seq: ROM model, scripted I2C slave and a scoreboard
// of expected I2C transactions pushed when each table is loaded.
module tb_clkgen_cfg_seq;

    localparam int unsigned POR_N = 16;
    localparam int unsigned GAP_N = 64;
    localparam int unsigned PLIM  = 3;
    localparam int unsigned RMAX  = 3;
`ifdef CFG_SEQ_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        start;
    logic [7:0]  tbl_addr;
    logic [31:0] tbl_data;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_dev;
    logic        req_rw;
    logic [7:0]  req_reg;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic        rsp_nack;
    logic [7:0]  rsp_rdata;
    logic        busy;
    logic        cfg_done;
    logic        cfg_err;
    logic [7:0]  err_index;

    always #5 sys_clk = ~sys_clk;

    clkgen_cfg_seq #(
        .POR_CYCLES(POR_N), .RETRY_MAX(RMAX), .POLL_LIMIT(PLIM), .POLL_GAP(GAP_N)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .req_valid(req_valid), .req_ready(req_ready), .req_dev(req_dev),
        .req_rw(req_rw), .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_rdata(rsp_rdata),
        .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .err_index(err_index)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // ROM: data valid one cycle after the address
    logic [31:0] rom [256];
    always @(posedge sys_clk) tbl_data <= rom[tbl_addr];

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    localparam logic [1:0] OPW = 2'b00, OPP = 2'b01, OPD = 2'b10, OPE = 2'b11;

    // reserved bits deliberately non-zero: they must have no effect
    function automatic logic [31:0] ent(input logic [1:0] op, input logic dsel,
                                        input logic [7:0] r, input logic [7:0] d,
                                        input logic [7:0] m);
        return {op, dsel, 5'b10110, r, d, m};
    endfunction

    // transaction word: {dev[6:0], rw, reg[7:0], wdata (0 for reads)}
    typedef logic [23:0] txn_t;
    txn_t       exp_q[$];
    logic [8:0] rsp_q[$];          // {nack, rdata} per transaction, in order
    logic [7:0] regfile [256];
    int         hs_cyc[$];
    int         hs_count   = 0;
    int         stall_left = 0;

    task automatic exp_wr(input logic [6:0] dev, input logic [7:0] r, input logic [7:0] d);
        exp_q.push_back({dev, 1'b0, r, d});
        if (RB != 0) exp_q.push_back({dev, 1'b1, r, 8'd0});
    endtask

    task automatic exp_rd(input logic [6:0] dev, input logic [7:0] r);
        exp_q.push_back({dev, 1'b1, r, 8'd0});
    endtask

    // scripted ack for a WRITE, plus the readback data when that feature is built in
    task automatic script_wr_ok(input logic [7:0] d);
        rsp_q.push_back(9'h000);
        if (RB != 0) rsp_q.push_back({1'b0, d});
    endtask

    function automatic txn_t cur_txn();
        return {req_dev, req_rw, req_reg, (req_rw ? 8'd0 : req_wdata)};
    endfunction

    // I2C slave: optional ready stall, scoreboard pop on handshake, response 2 cycles later
    initial begin
        txn_t       snap;
        txn_t       exp_t;
        logic       stall_active;
        int         pend;
        logic       pend_nack;
        logic [7:0] pend_rdata;
        snap = 24'd0; stall_active = 1'b0; pend = 0; pend_nack = 1'b0; pend_rdata = 8'd0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_rdata = 8'd0;
        forever begin
            @(negedge sys_clk);
            rsp_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    rsp_valid = 1'b1; rsp_nack = pend_nack; rsp_rdata = pend_rdata;
                end
            end
            if (req_ready) begin
                req_ready = 1'b0;
                hs_count++;
                hs_cyc.push_back(cyc);
                check_val("req_valid_drop", 32'(req_valid), 32'd0);
                check_val("txn_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_t = exp_q.pop_front();
                    check_val("txn", 32'(snap), 32'(exp_t));
                end
                if (rsp_q.size() != 0) {pend_nack, pend_rdata} = rsp_q.pop_front();
                else begin
                    pend_nack  = 1'b0;
                    pend_rdata = snap[16] ? regfile[snap[15:8]] : 8'd0;
                end
                if (!pend_nack && !snap[16]) regfile[snap[15:8]] = snap[7:0];
                pend = 2;
            end else if (req_valid) begin
                if (!stall_active) begin
                    snap = cur_txn();
                    stall_active = 1'b1;
                end else begin
                    check_val("req_stable", 32'(cur_txn()), 32'(snap));
                end
                if (stall_left > 0) stall_left--;
                else begin
                    req_ready = 1'b1;
                    stall_active = 1'b0;
                end
            end
        end
    end

    task automatic wait_end(input int budget, input string tag);
        int t = 0;
        while (!(cfg_done || cfg_err) && t < budget) begin
            @(negedge sys_clk);
            t++;
        end
        check_val(tag, 32'(cfg_done || cfg_err), 32'd1);
    endtask

    task automatic wait_valid(input int budget, output int t);
        t = 0;
        while (!req_valid && t < budget) begin
            @(negedge sys_clk);
            t++;
        end
    endtask

    task automatic pulse_start();
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int hs0;
        sys_rst = 1'b1;
        start   = 1'b0;
        for (int i = 0; i < 256; i++) begin
            rom[i]     = ent(OPE, 1'b0, 8'd0, 8'd0, 8'd0);
            regfile[i] = 8'd0;
        end

        // T1: single write with a 5-cycle ready stall
        rom[0] = ent(OPW, 1'b0, 8'hB7, 8'hC0, 8'h00);
        stall_left = 5;
        exp_wr(7'h60, 8'hB7, 8'hC0);
        repeat (2) @(negedge sys_clk);
        check_val("rst_tbl_addr", 32'(tbl_addr), 32'd0);
        check_val("rst_req_valid", 32'(req_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_cfg_done", 32'(cfg_done), 32'd0);
        check_val("rst_cfg_err", 32'(cfg_err), 32'd0);
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        check_val("por_busy", 32'(busy), 32'd1);
        check_val("por_quiet", 32'(req_valid), 32'd0);
        wait_valid(100, t);
        check_val("por_latency", 32'((t + 3) >= int'(POR_N) && (t + 3) <= int'(POR_N) + 4), 32'd1);
        wait_end(500, "t1_end");
        check_val("t1_done", 32'(cfg_done), 32'd1);
        check_val("t1_busy", 32'(busy), 32'd0);
        check_val("t1_err", 32'(cfg_err), 32'd0);
        check_val("t1_hs", 32'(hs_count), 32'(1 + RB));

        // T2: NACK three times then ACK, restarted from DONE
        for (int i = 0; i < 3; i++) begin
            rsp_q.push_back(9'h100);
            exp_q.push_back({7'h60, 1'b0, 8'hB7, 8'hC0});
        end
        exp_wr(7'h60, 8'hB7, 8'hC0);
        hs0 = hs_count;
        pulse_start();
        check_val("t2_done_clr", 32'(cfg_done), 32'd0);
        wait_valid(20, t);
        check_val("t2_no_por", 32'(t <= 4), 32'd1);
        wait_end(500, "t2_end");
        check_val("t2_done", 32'(cfg_done), 32'd1);
        check_val("t2_hs", 32'(hs_count - hs0), 32'(4 + RB));

        // T3: NACK four times -> error on entry 0
        for (int i = 0; i < 4; i++) begin
            rsp_q.push_back(9'h100);
            exp_q.push_back({7'h60, 1'b0, 8'hB7, 8'hC0});
        end
        hs0 = hs_count;
        pulse_start();
        wait_end(500, "t3_end");
        repeat (10) @(negedge sys_clk);
        check_val("t3_err", 32'(cfg_err), 32'd1);
        check_val("t3_done", 32'(cfg_done), 32'd0);
        check_val("t3_err_index", 32'(err_index), 32'd0);
        check_val("t3_busy", 32'(busy), 32'd0);
        check_val("t3_hs", 32'(hs_count - hs0), 32'd4);

        // T4: POLL with three mismatches, DELAY 2, WRITE dev1; restarted from ERROR
        rom[0] = ent(OPP, 1'b1, 8'hDA, 8'h00, 8'h11);
        rom[1] = ent(OPD, 1'b0, 8'h00, 8'h00, 8'h02);
        rom[2] = ent(OPW, 1'b1, 8'h10, 8'h5A, 8'h00);
        rom[3] = ent(OPE, 1'b0, 8'h00, 8'h00, 8'h00);
        rsp_q.push_back(9'h011); rsp_q.push_back(9'h011);
        rsp_q.push_back(9'h001); rsp_q.push_back(9'h000);
        for (int i = 0; i < 4; i++) exp_rd(7'h70, 8'hDA);
        exp_wr(7'h70, 8'h10, 8'h5A);
        hs_cyc.delete();
        pulse_start();
        check_val("t4_err_clr", 32'(cfg_err), 32'd0);
        check_val("t4_idx_clr", 32'(err_index), 32'd0);
        wait_end(20000, "t4_end");
        check_val("t4_done", 32'(cfg_done), 32'd1);
        check_val("t4_hs_n", 32'(hs_cyc.size()), 32'(5 + RB));
        if (hs_cyc.size() >= 5) begin
            for (int i = 1; i < 4; i++)
                check_val("t4_poll_gap", 32'((hs_cyc[i] - hs_cyc[i-1]) >= int'(GAP_N)), 32'd1);
            check_val("t4_delay_len", 32'((hs_cyc[4] - hs_cyc[3]) >= 2048 &&
                                          (hs_cyc[4] - hs_cyc[3]) <= 2048 + 40), 32'd1);
        end

        // T5: WRITE, zero DELAY, then POLL failing PLIM+1 times at entry 2
        rom[0] = ent(OPW, 1'b0, 8'h01, 8'h11, 8'h00);
        rom[1] = ent(OPD, 1'b0, 8'h00, 8'h00, 8'h00);
        rom[2] = ent(OPP, 1'b0, 8'h02, 8'h80, 8'h80);
        script_wr_ok(8'h11);
        for (int i = 0; i < 4; i++) rsp_q.push_back(9'h07F);
        exp_wr(7'h60, 8'h01, 8'h11);
        for (int i = 0; i < 4; i++) exp_rd(7'h60, 8'h02);
        hs0 = hs_count;
        pulse_start();
        wait_end(2000, "t5_end");
        check_val("t5_err", 32'(cfg_err), 32'd1);
        check_val("t5_err_index", 32'(err_index), 32'd2);
        check_val("t5_hs", 32'(hs_count - hs0), 32'(5 + RB));

        // T6: reset while waiting for a response; the late response must be ignored
        rom[0] = ent(OPW, 1'b0, 8'h20, 8'h33, 8'h00);
        rom[1] = ent(OPE, 1'b0, 8'h00, 8'h00, 8'h00);
        exp_q.push_back({7'h60, 1'b0, 8'h20, 8'h33});
        hs0 = hs_count;
        pulse_start();
        t = 0;
        while (hs_count == hs0 && t < 50) begin
            @(negedge sys_clk);
            #1;
            t++;
        end
        check_val("t6_hs_seen", 32'(hs_count - hs0), 32'd1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check_val("t6_tbl_addr", 32'(tbl_addr), 32'd0);
        check_val("t6_req_valid", 32'(req_valid), 32'd0);
        check_val("t6_req_dev", 32'(req_dev), 32'd0);
        check_val("t6_req_rw", 32'(req_rw), 32'd0);
        check_val("t6_req_reg", 32'(req_reg), 32'd0);
        check_val("t6_req_wdata", 32'(req_wdata), 32'd0);
        check_val("t6_busy", 32'(busy), 32'd0);
        check_val("t6_cfg_done", 32'(cfg_done), 32'd0);
        check_val("t6_cfg_err", 32'(cfg_err), 32'd0);
        check_val("t6_err_index", 32'(err_index), 32'd0);
        sys_rst = 1'b0;
        exp_wr(7'h60, 8'h20, 8'h33);
        wait_valid(100, t);
        check_val("t6_por_again", 32'(t >= int'(POR_N)), 32'd1);
        wait_end(500, "t6_end");
        check_val("t6_done", 32'(cfg_done), 32'd1);

`ifdef CFG_SEQ_READBACK_EN
        // readback of 0x80 against 0xC0 costs one retry
        rom[0] = ent(OPW, 1'b0, 8'hB7, 8'hC0, 8'h00);
        rsp_q.push_back(9'h000);
        rsp_q.push_back(9'h080);
        exp_wr(7'h60, 8'hB7, 8'hC0);
        exp_wr(7'h60, 8'hB7, 8'hC0);
        hs0 = hs_count;
        pulse_start();
        wait_end(500, "rb_end");
        check_val("rb_done", 32'(cfg_done), 32'd1);
        check_val("rb_hs", 32'(hs_count - hs0), 32'd4);
`endif

        repeat (5) @(negedge sys_clk);
        check_val("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
